// File: rtl/alu_sequencer.sv
// alu_sequencer: button-driven A/B/op load sequencer that captures the ALU result into a held register.
// Set ALU_SEQ_DEBOUNCE_EN to include the button debouncer. Without it, the edge detector works on the synchronized level.
module alu_sequencer #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_go,
  input  logic       btn_clr,
  input  logic [7:0] sw_data,
  input  logic [3:0] sw_op,
  input  logic [7:0] alu_y,
  output logic [7:0] reg_a,
  output logic [7:0] reg_b,
  output logic [3:0] alu_op,
  output logic [7:0] result,
  output logic       result_valid,
  output logic [1:0] state
);
  typedef enum logic [1:0] {S_A, S_B, S_EXEC, S_DONE} state_t;
  logic [1:0] s1_q, s1_d, s2_q, s2_d, prev_q, prev_d, pls_q, pls_d, lvl;
  logic       go_p, clr_p;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES);
  logic [1:0]         deb_q, deb_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = '0;
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != deb_q[i]) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
        if (cnt_q[i] == CW'(DEB_CYCLES - 1)) begin
          deb_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q <= '0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end
  assign lvl = deb_q;
`else
  logic unused_deb;
  assign unused_deb = (DEB_CYCLES < 2);
  assign lvl = s2_q;
`endif
  always_comb begin
    s1_d   = {btn_clr, btn_go};
    s2_d   = s1_q;
    prev_d = lvl;
    pls_d  = lvl & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      pls_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      pls_q  <= pls_d;
    end
  end
  assign go_p  = pls_q[0];
  assign clr_p = pls_q[1];
  state_t     st_q, st_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0] op_q, op_d;
  logic       val_q, val_d;
  always_comb begin
    st_d  = st_q;
    a_d   = a_q;
    b_d   = b_q;
    op_d  = op_q;
    res_d = res_q;
    val_d = val_q;
    if (clr_p) begin
      st_d  = S_A;
      a_d   = '0;
      b_d   = '0;
      op_d  = '0;
      res_d = '0;
      val_d = 1'b0;
    end else begin
      case (st_q)
        S_A: if (go_p) begin
          a_d  = sw_data;
          st_d = S_B;
        end
        S_B: if (go_p) begin
          b_d  = sw_data;
          op_d = sw_op;
          st_d = S_EXEC;
        end
        S_EXEC: begin
          res_d = alu_y;
          val_d = 1'b1;
          st_d  = S_DONE;
        end
        default: if (go_p) begin
          a_d   = sw_data;
          val_d = 1'b0;
          st_d  = S_B;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= S_A;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      res_q <= '0;
      val_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      a_q   <= a_d;
      b_q   <= b_d;
      op_q  <= op_d;
      res_q <= res_d;
      val_q <= val_d;
    end
  end
  assign reg_a        = a_q;
  assign reg_b        = b_q;
  assign alu_op       = op_q;
  assign result       = res_q;
  assign result_valid = val_q;
  assign state        = st_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: randomized button/switch stimulus checked against a transaction-level model of the sequencer.
module tb_alu_sequencer;
  localparam int DEB = 4;
`ifdef ALU_SEQ_DEBOUNCE_EN
  localparam int LAT = DEB + 3, MINH = DEB;
`else
  localparam int LAT = 3, MINH = 1;
`endif
  logic       clk = 0, rst_n = 0, btn_go = 0, btn_clr = 0;
  logic [7:0] sw_data = 0;
  logic [3:0] sw_op = 0;
  logic [7:0] alu_y, reg_a, reg_b, result;
  logic [3:0] alu_op;
  logic       result_valid;
  logic [1:0] state;
  int total = 0, bad = 0;
  logic [7:0] m_a = 0, m_b = 0, m_res = 0;
  logic [3:0] m_op = 0;
  logic       m_val = 0;
  logic [1:0] m_st = 0;

  alu_sequencer #(.DEB_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .btn_go(btn_go), .btn_clr(btn_clr),
    .sw_data(sw_data), .sw_op(sw_op), .alu_y(alu_y),
    .reg_a(reg_a), .reg_b(reg_b), .alu_op(alu_op), .result(result),
    .result_valid(result_valid), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [7:0] a, b, input logic [3:0] op);
    case (op)
      4'd1:    return a - b;
      4'd2:    return a ^ b;
      4'd3:    return a + b;
      4'd4:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_y = alu_f(reg_a, reg_b, alu_op);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("reg_a", {24'd0, reg_a}, {24'd0, m_a});
    chk("reg_b", {24'd0, reg_b}, {24'd0, m_b});
    chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
    chk("result", {24'd0, result}, {24'd0, m_res});
    chk("valid", {31'd0, result_valid}, {31'd0, m_val});
    chk("state", {30'd0, state}, {30'd0, m_st});
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_val = 0; m_st = 0;
  endtask

  task automatic press(input logic g, input logic c, input int hold, input logic [7:0] d, input logic [3:0] op);
    int ng = 0, nc = 0, fg = 0, fc = 0, fv = 0;
    logic fire, was_b;
    was_b = (m_st == 2'd1);
    fire = (hold >= MINH);
    @(negedge clk);
    sw_data = d; sw_op = op; btn_go = g; btn_clr = c;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dut.go_p) begin ng++; if (fg == 0) fg = k; end
      if (dut.clr_p) begin nc++; if (fc == 0) fc = k; end
      if (result_valid && fv == 0) fv = k;
      if (k == hold) begin btn_go = 0; btn_clr = 0; end
    end
    chk("go_pulses", ng, (g && fire) ? 1 : 0);
    chk("clr_pulses", nc, (c && fire) ? 1 : 0);
    if (g && fire) chk("go_lat", fg, LAT);
    if (c && fire) chk("clr_lat", fc, LAT);
    if (fire && c) model_clear();
    else if (fire && g) begin
      case (m_st)
        2'd0: begin m_a = d; m_st = 1; end
        2'd1: begin
          m_b = d; m_op = op; m_res = alu_f(m_a, d, op); m_val = 1; m_st = 3;
        end
        default: begin m_a = d; m_val = 0; m_st = 1; end
      endcase
      if (was_b) chk("valid_lat", fv, LAT + 2);
    end
    check_all();
  endtask

  task automatic reset_seq(input logic hold_go, input logic [7:0] d);
    int ng = 0;
    @(negedge clk);
    rst_n = 0; btn_go = hold_go; sw_data = d;
    repeat (3) @(negedge clk);
    model_clear();
    check_all();
    rst_n = 1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (dut.go_p) ng++;
      if (k == 20) btn_go = 0;
    end
    chk("rst_hold_pulses", ng, hold_go ? 1 : 0);
    if (hold_go) begin m_a = d; m_st = 1; end
    check_all();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1;
    press(1, 0, 20, 8'h12, 4'h0);
    press(1, 0, 20, 8'h34, 4'h3);
    chk("res_46", {24'd0, result}, 32'h46);
    press(1, 0, 3, 8'h55, 4'h0);
    press(1, 1, 20, 8'h77, 4'h2);
    press(1, 0, 20, 8'hAB, 4'h0);
    press(1, 0, 20, 8'hCD, 4'h1);
    press(1, 0, 20, 8'hFF, 4'h0);
    chk("restart_a", {24'd0, reg_a}, 32'hFF);
    chk("restart_b", {24'd0, reg_b}, 32'hCD);
    reset_seq(1, 8'h5A);
    press(0, 1, DEB + 2, 8'h00, 4'h0);
    for (int n = 0; n < 50; n++) begin
      int r;
      logic [7:0] d;
      logic [3:0] op;
      r = $urandom_range(0, 9);
      d = 8'($urandom);
      op = 4'($urandom);
      if (r <= 5) press(1, 0, $urandom_range(DEB, 20), d, op);
      else if (r == 6) press(0, 1, $urandom_range(DEB, 20), d, op);
      else if (r == 7) press(1, 1, $urandom_range(DEB, 20), d, op);
      else press(1, 0, $urandom_range(1, DEB - 1), d, op);
    end
    reset_seq(0, 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Controller that sequences the 8-bit ALU datapath from the board's switches and buttons. It conditions the raw `btnC`/`btnU` pushbuttons, loads operands A and B from `sw[15:8]`, latches the opcode from `sw[3:0]`, and presents registered operands/opcode to the combinational ALU. It then captures the ALU result into a held result register. It sits between the top-level I/O and the ALU, and its registered outputs drive the LEDs and the display.

## Interface
Parameters:
- `DEB_CYCLES`, 1000000, cycles a button level must be stable before it is accepted (10 ms at 100 MHz); minimum 2.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `btn_go`  in  1  raw, asynchronous `btnC`; a press advances the sequence.
- `btn_clr`  in  1  raw, asynchronous `btnU`; a press clears the operands and result.
- `sw_data`  in  8  operand switches (`sw[15:8]`).
- `sw_op`  in  4  opcode switches (`sw[3:0]`).
- `alu_y`  in  8  combinational ALU result for `reg_a`/`reg_b`/`alu_op`.
- `reg_a`  out  8  operand A register (to ALU, `led[15:8]`).
- `reg_b`  out  8  operand B register (to ALU, `led[7:0]`).
- `alu_op`  out  4  latched opcode register (to ALU).
- `result`  out  8  captured result (`Y`, display).
- `result_valid`  out  1  high while `result` holds a result for the current A/B/op.
- `state`  out  2  FSM state code, for display: 0 = S_A, 1 = S_B, 2 = S_EXEC, 3 = S_DONE.

## Operation
- **Button conditioning.** Both buttons use identical logic:
  - 2-flop synchronizer.
  - Debouncer: the counter increments while the synchronized level differs from the debounced level and clears when they match. When the count reaches `DEB_CYCLES-1` with the levels still differing, the debounced level takes the synchronized value.
  - Registered rising-edge detector produces a 1-cycle pulse: `go_p` for `btn_go`, `clr_p` for `btn_clr`.
- **FSM.**
  - S_A: on `go_p`, `reg_a <= sw_data` and go to S_B.
  - S_B: on `go_p`, `reg_b <= sw_data`, `alu_op <= sw_op`, and go to S_EXEC.
  - S_EXEC: unconditional, one cycle. `result <= alu_y`, `result_valid <= 1`, and go to S_DONE.
  - S_DONE: hold everything. On `go_p`, `reg_a <= sw_data`, `result_valid <= 0`, and go to S_B. This starts a new calculation while keeping the old B visible until it is overwritten.
- **Clear.** `clr_p` in any state sets `reg_a`, `reg_b`, `alu_op`, `result` and `result_valid` to 0 and forces S_A.
- **Simultaneous events.**
  - `clr_p` and `go_p` in the same cycle: clear wins and `go_p` is discarded.
  - `go_p` arriving in S_EXEC is discarded, not queued.
- **Reset.** `rst_n = 0` at a clock edge, including mid-sequence, gives:
  - all data outputs 0;
  - `state` = 0 (S_A);
  - debouncers: debounced levels 0, counters 0, synchronizers 0, edge-detector history 0.
  - A button already held through reset release therefore produces one pulse after debounce.
- **Widths.** `result` is `alu_y` unmodified. No arithmetic is done in this block.

## Timing
- Raw button rise, held stable → `go_p`/`clr_p` asserted exactly `DEB_CYCLES+3` cycles later. This is 2 cycles of sync, `DEB_CYCLES` of debounce and 1 of edge detection.
- Glitches shorter than `DEB_CYCLES` cycles produce no pulse. Release generates no pulse.
- Register updates take effect on the edge on which `go_p` is sampled.
- `alu_y` must be valid one cycle after `reg_b`/`alu_op` update. `result` is captured at the end of S_EXEC.
- From the `go_p` sample in S_B, `result_valid` rises 2 cycles later.
- Holding a button produces one pulse only.

## Configuration
- `ALU_SEQ_DEBOUNCE_EN`
  - Defined: debouncer present as described; `DEB_CYCLES` is honoured.
  - Undefined: debouncer removed. The edge detector acts on the synchronized level, press-to-pulse latency is 3 cycles, and `DEB_CYCLES` is ignored.
  - FSM behaviour is identical in both builds.

## Test plan
Bench settings: `DEB_CYCLES=4`, with the macro defined unless noted.
- **Reset.** Hold `rst_n=0` for 3 cycles → all outputs 0, `state=0`.
- **Full sequence.**
  - `sw_data=0x12` and a go press → `reg_a=0x12`, `state=1`.
  - `sw_data=0x34`, `sw_op=0x3` and a go press → `reg_b=0x34`, `alu_op=3`.
  - ALU model returns `0x46` → 2 cycles later `result=0x46`, `result_valid=1`, `state=3`.
- **Glitch rejection and latency.**
  - `btn_go` high for 3 cycles → no state change.
  - `btn_go` high for 20 cycles → exactly one `go_p`, 7 cycles after the rise.
- **Clear priority.** In S_DONE, press `btn_go` and `btn_clr` with the same rise cycle → `reg_a=reg_b=result=0`, `result_valid=0`, `state=0`.
- **Restart from S_DONE.** Go press with `sw_data=0xFF` → `reg_a=0xFF`, `reg_b` unchanged, `result_valid=0`, `state=1`.
- **Debounce compiled out.** With `ALU_SEQ_DEBOUNCE_EN` undefined, a 1-cycle `btn_go` pulse → `go_p` 3 cycles later and `state` advances S_A→S_B.
